prio_idx_decoder_seq: RTL and testbench
=======================================

Name: prio_idx_decoder_seq

Overview:
- Sequential counterpart to the 4-to-2 priority encoder: accepts a stream of encoded indices (encoder's out/v pair) and regenerates the one-hot line.
- Indices are buffered in a small FIFO. Each one drives its one-hot output for a fixed number of cycles.
- Sits downstream of the priority encoder to turn the winning index back into per-line grant/enable pulses.

Parameters:
- IDX_W, 2, index width; number of output lines NUM_OUT = 2**IDX_W (localparam, derived).
- FIFO_DEPTH, 4, pending-index buffer depth; power of two, ≥2.
- HOLD, 3, cycles each one-hot grant is held; ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_v  in  1  index valid (the encoder's v)
- in_idx  in  IDX_W  encoded index (the encoder's out)
- in_rdy  out  1  FIFO can accept; transfer when in_v && in_rdy
- out_onehot  out  NUM_OUT  registered one-hot grant, bit in_idx set
- out_v  out  1  grant active (equals |out_onehot)
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  entries pending

Behaviour:
- Reset (async assert, sync deassert expected from top):
  - out_onehot=0, out_v=0, fifo_cnt=0, in_rdy=1.
  - FSM goes to IDLE; FIFO pointers and hold counter are cleared.
- Reset mid-grant aborts the grant immediately and discards all pending entries.
- FIFO:
  - in_rdy = (fifo_cnt != FIFO_DEPTH), purely from registered count; no same-cycle pass-through when full.
  - Push on in_v && in_rdy. in_idx is ignored when in_v=0.
  - Simultaneous push and pop: count unchanged, both occur.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if fifo_cnt>0, pop head, load out_onehot = 1<<head, set out_v, load hold_cnt=HOLD-1, go DRIVE. Otherwise stay; outputs 0.
  - DRIVE: outputs held. If hold_cnt>0, decrement. At hold_cnt==0, clear outputs at next edge and go GAP (macro on) or IDLE (macro off).
  - GAP: outputs 0 for exactly one cycle, then IDLE.
- Latency: index pushed at edge t is counted at t; IDLE pops at edge t+1; out_onehot valid from t+1 through t+HOLD.
- Back-to-back with macro off:
  - DRIVE at hold_cnt==0 with fifo_cnt>0 pops the next entry directly (DRIVE→DRIVE), so there are no idle cycles.
  - Same index twice gives an unbroken 2*HOLD-cycle pulse.
- HOLD=1: each grant lasts exactly one cycle.
- out_onehot is never multi-hot; out_v=0 implies out_onehot=0.

Optional Feature:
- Macro PRIO_DEC_GAP_EN.
  - Defined: GAP state is present; one all-zero cycle between consecutive grants, guaranteeing a visible edge per grant.
  - Undefined: GAP state is compiled out; direct DRIVE→DRIVE chaining as described above.

Decomposition:
- Package prio_dec_pkg: FSM state enum (IDLE, DRIVE, GAP), default IDX_W/FIFO_DEPTH/HOLD constants, and a function onehot_of(idx).
- Sub-module prio_idx_fifo: synchronous FIFO with count, async active-low reset. The top holds the FSM, hold counter and output register.

Test Plan:
- Reset, then single push idx=2 at edge t → out_onehot=4'b0100, out_v=1 for edges t+1..t+3, then 0; fifo_cnt 1→0.
- Push idx=3,0,1,2 on consecutive cycles with no backpressure, in_rdy stays 1.
  - Macro off: one-hots 1000,0001,0010,0100 each 3 cycles, contiguous.
  - Macro on: one zero cycle between each.
- Push 5 indices while first grant is active → in_rdy=0 after FIFO fills (fifo_cnt=4); 5th held by source until pop; all 5 emitted in order.
- in_v=0 with in_idx toggling → no push, outputs stay 0.
- rst_n low mid-DRIVE with fifo_cnt=3 → outputs 0 and fifo_cnt=0 asynchronously, before the next edge; after release, FSM is IDLE with nothing emitted.
- HOLD=1, push idx=1 twice, macro off → out_onehot=0010 for two consecutive cycles.

Source files
------------

// File: rtl/prio_dec_pkg.sv
// prio_dec_pkg: FSM states, default sizing and the one-hot helper shared by prio_idx_decoder_seq.
package prio_dec_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
    localparam int DEF_IDX_W = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_HOLD = 3;
    function automatic logic [31:0] onehot_of(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/prio_idx_fifo.sv
// prio_idx_fifo: pending-index FIFO with occupancy count; pointers wrap naturally (DEPTH is a power of two).
module prio_idx_fifo
    import prio_dec_pkg::*;
#(
    parameter int W = DEF_IDX_W,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] cnt
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/prio_idx_decoder_seq.sv
// prio_idx_decoder_seq: replays buffered indices as one-hot grants held HOLD cycles each.
// Define PRIO_DEC_GAP_EN to insert one all-zero cycle between consecutive grants.
module prio_idx_decoder_seq
    import prio_dec_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int HOLD = DEF_HOLD,
    localparam int NUM_OUT = 2 ** IDX_W,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_v,
    input  logic [IDX_W-1:0]   in_idx,
    output logic               in_rdy,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic               out_v,
    output logic [CW-1:0]      fifo_cnt
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    state_t state, state_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [NUM_OUT-1:0] onehot_nx, head_oh;
    logic [IDX_W-1:0] head;
    logic pop, can_load;
    assign in_rdy = fifo_cnt != CW'(FIFO_DEPTH);
    assign out_v = |out_onehot;
    assign head_oh = NUM_OUT'(onehot_of(5'(head)));
    prio_idx_fifo #(.W(IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(in_v && in_rdy),
        .pop(pop),
        .wdata(in_idx),
        .rdata(head),
        .cnt(fifo_cnt)
    );
    // GAP behaves like IDLE on its way out so exactly one zero cycle separates grants
`ifdef PRIO_DEC_GAP_EN
    assign can_load = state == IDLE || state == GAP;
`else
    assign can_load = state == IDLE || (state == DRIVE && hold_cnt == '0);
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            hold_cnt <= '0;
            out_onehot <= '0;
        end else begin
            state <= state_nx;
            hold_cnt <= hold_nx;
            out_onehot <= onehot_nx;
        end
    always_comb begin
        state_nx = state;
        hold_nx = hold_cnt;
        onehot_nx = '0;
        pop = 1'b0;
        if (state == DRIVE && hold_cnt != '0) begin
            hold_nx = hold_cnt - HW'(1);
            onehot_nx = out_onehot;
        end else if (can_load && fifo_cnt != '0) begin
            pop = 1'b1;
            onehot_nx = head_oh;
            hold_nx = HW'(HOLD - 1);
            state_nx = DRIVE;
        end else begin
`ifdef PRIO_DEC_GAP_EN
            state_nx = state == DRIVE ? GAP : IDLE;
`else
            state_nx = IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_prio_idx_decoder_seq.sv
// tb_prio_idx_decoder_seq: randomized stream against a schedule model (each grant's start edge derived from push time).
// Honours PRIO_DEC_GAP_EN in the same way as the design.
module tb_prio_idx_decoder_seq;
    localparam int HOLD = 3;
    localparam int DEPTH = 4;
`ifdef PRIO_DEC_GAP_EN
    localparam int GAPX = 1;
`else
    localparam int GAPX = 0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_v = 1'b0, in_rdy, out_v;
    logic [1:0] in_idx = '0;
    logic [3:0] out_onehot;
    logic [2:0] fifo_cnt;
    logic v1 = 1'b0, rdy1, ov1;
    logic [1:0] idx1 = '0;
    logic [3:0] oh1;
    logic [2:0] cnt1;
    int cyc = 0, checks = 0, passed = 0;
    logic [8:0] obs;
    int g_start[$], g_push[$];
    logic [1:0] g_idx[$];

    prio_idx_decoder_seq dut (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_idx(in_idx), .in_rdy(in_rdy),
        .out_onehot(out_onehot), .out_v(out_v), .fifo_cnt(fifo_cnt)
    );
    prio_idx_decoder_seq #(.HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_v(v1), .in_idx(idx1), .in_rdy(rdy1),
        .out_onehot(oh1), .out_v(ov1), .fifo_cnt(cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_oh(int c);
        logic [3:0] r = '0;
        foreach (g_start[k]) if (c >= g_start[k] && c < g_start[k] + HOLD) r = 4'b0001 << g_idx[k];
        return r;
    endfunction

    function automatic int exp_cnt(int c);
        int n = 0;
        foreach (g_start[k]) if (g_push[k] <= c && g_start[k] > c) n++;
        return n;
    endfunction

    function automatic logic [8:0] exp_vec(int c);
        logic [3:0] oh = exp_oh(c);
        int n = exp_cnt(c);
        return {oh, |oh, 3'(n), n != DEPTH};
    endfunction

    task automatic model_clear();
        g_start.delete();
        g_push.delete();
        g_idx.delete();
    endtask

    // one clock: drive at negedge, record any accepted push, sample at next negedge
    task automatic tick(input logic v, input logic [1:0] i);
        in_v = v;
        in_idx = i;
        @(posedge clk);
        cyc++;
        if (v && exp_cnt(cyc - 1) != DEPTH) begin
            int st = cyc + 1;
            if (g_start.size() > 0 && g_start[$] + HOLD + GAPX > st) st = g_start[$] + HOLD + GAPX;
            g_start.push_back(st);
            g_push.push_back(cyc);
            g_idx.push_back(i);
        end
        @(negedge clk);
        obs = {out_onehot, out_v, fifo_cnt, in_rdy};
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 9'b0) begin end
        obs = {out_onehot, out_v, fifo_cnt, in_rdy};
        if (obs !== 9'b0000_0_000_1) $display("FAIL reset_dut got=%b exp=%b", obs, 9'b0000_0_000_1);
        else passed++;
        checks++;
        if ({oh1, ov1, cnt1, rdy1} !== 9'b0000_0_000_1) $display("FAIL reset_dut1 got=%b exp=%b", {oh1, ov1, cnt1, rdy1}, 9'b0000_0_000_1);
        else passed++;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_burst();
        logic [1:0] seq [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        for (int k = 0; k < 24; k++) begin
            tick(k < 4, k < 4 ? seq[k] : 2'd0);
            checks++;
            if (obs !== exp_vec(cyc)) $display("FAIL burst cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 45; k++) begin
            tick(k < 12, 2'($urandom_range(0, 3)));
            checks++;
            if (obs !== exp_vec(cyc)) $display("FAIL backpressure cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 120; k++) begin
            tick(k < 100 && $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)));
            checks++;
            if (obs !== exp_vec(cyc)) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
            else passed++;
        end
    endtask

    task automatic test_no_push();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 2'($urandom_range(0, 3)));
            checks++;
            if (obs !== 9'b0000_0_000_1) $display("FAIL no_push cyc=%0d got=%b exp=%b", cyc, obs, 9'b0000_0_000_1);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, seq[k]);
            checks++;
            if (obs !== exp_vec(cyc)) $display("FAIL reset_mid_fill cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
            else passed++;
        end
        in_v = 1'b0;
        #2 rst_n = 1'b0;
        #1 obs = {out_onehot, out_v, fifo_cnt, in_rdy};
        checks++;
        if (obs !== 9'b0000_0_000_1) $display("FAIL reset_mid_async got=%b exp=%b", obs, 9'b0000_0_000_1);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 2'd0);
            checks++;
            if (obs !== 9'b0000_0_000_1) $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, obs, 9'b0000_0_000_1);
            else passed++;
        end
    endtask

    task automatic test_hold1();
        logic [3:0] eoh [5];
        logic [2:0] ecnt [5];
        logic [8:0] e;
`ifdef PRIO_DEC_GAP_EN
        eoh = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
        ecnt = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
`else
        eoh = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        ecnt = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
`endif
        v1 = 1'b1;
        idx1 = 2'd1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 2'd0);
            if (k == 1) v1 = 1'b0;
            e = {eoh[k], |eoh[k], ecnt[k], 1'b1};
            checks++;
            if ({oh1, ov1, cnt1, rdy1} !== e) $display("FAIL hold1 step=%0d got=%b exp=%b", k, {oh1, ov1, cnt1, rdy1}, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_no_push();
        test_reset_mid();
        test_random();
        test_hold1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
